alu_mul_sequencer: RTL and testbench

- Multi-cycle shift-add multiply engine and its sequencer, sitting beside the EX-stage ALU.
- When the EX stage issues the multiply ALU control code, the block latches the operands, stalls the pipeline, iterates one multiplier bit per cycle, then returns the low WIDTH bits of the product.
- All other ALU control codes pass untouched; no stall.

---
 rtl/alu_mul_sequencer.sv | 91 +++++++++
 tb/tb_alu_mul_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-add multiplier and sequencer beside the EX-stage ALU.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module alu_mul_sequencer #(
  parameter int          WIDTH    = 32,
  parameter logic [2:0]  MUL_CODE = 3'b111
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       aluctrl_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplier, result;
  logic [WIDTH-1:0] acc_step;
  logic [CW-1:0]    count;
  logic             accept, last, skip;

  assign accept   = start_i && (aluctrl_i == MUL_CODE) && (state == IDLE) && !flush_i;
  assign last     = (count == CW'(WIDTH - 1));
  assign acc_step = mplier[0] ? acc + mcand : acc;

`ifdef MUL_EARLY_EXIT_EN
  assign skip = (mplier == '0);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        stall_o = accept;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        // A flush releases the pipeline in the same cycle and drops the product.
        if (flush_i) state_nxt = IDLE;
        else begin
          stall_o = 1'b1;
          if (skip || last) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand  <= data1_i;
        mplier <= data2_i;
        acc    <= '0;
        count  <= '0;
      end else if (state == RUN && !skip) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end
      // Capture the final sum so result_o is valid during DONE and held afterwards.
      if (state == RUN && state_nxt == DONE)
        result <= skip ? acc : acc_step;
    end
  end

  assign busy_o   = (state == RUN);
  assign done_o   = (state == DONE);
  assign result_o = result;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: latency, results, flush, reset, no re-accept.
module tb_alu_mul_sequencer;
  localparam int         WIDTH = 32;
  localparam logic [2:0] MUL   = 3'b111;

  logic             clk_i = 1'b0;
  logic             rst_i, start_i, flush_i;
  logic [2:0]       aluctrl_i;
  logic [WIDTH-1:0] data1_i, data2_i;
  logic             stall_o, busy_o, done_o;
  logic [WIDTH-1:0] result_o;

  int nchk = 0;
  int nerr = 0;

  alu_mul_sequencer #(.WIDTH(WIDTH), .MUL_CODE(MUL)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .aluctrl_i(aluctrl_i),
    .flush_i  (flush_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven 1ns after the edge, outputs checked 1ns later.
  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic b, input logic d);
    chk({tag, ".stall"}, 32'(stall_o), 32'(s));
    chk({tag, ".busy"},  32'(busy_o),  32'(b));
    chk({tag, ".done"},  32'(done_o),  32'(d));
  endtask

  // Issue a multiply in the current cycle T; expect DONE at T+lat with result exp.
  task automatic run_mul(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp, input int lat);
    start_i = 1'b1; aluctrl_i = MUL; flush_i = 1'b0; data1_i = a; data2_i = b;
    #1;
    chk_ctl({tag, ".T"}, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < lat; i++) begin
      next_cyc();
      data1_i = ~a; data2_i = $urandom;
      #1;
      chk_ctl({tag, ".run"}, 1'b1, 1'b1, 1'b0);
    end
    next_cyc();
    #1;
    chk_ctl({tag, ".done"}, 1'b0, 1'b0, 1'b1);
    chk({tag, ".result"}, result_o, exp);
    next_cyc();
    // A DONE-cycle re-accept would show up here as busy.
    chk({tag, ".no_reacc"}, 32'(busy_o), 32'd0);
    start_i = 1'b0;
    #1;
    chk_ctl({tag, ".after"}, 1'b0, 1'b0, 1'b0);
    chk({tag, ".hold"}, result_o, exp);
  endtask

`ifdef MUL_EARLY_EXIT_EN
  function automatic int lat_of(input int ee);
    return ee;
  endfunction
`else
  function automatic int lat_of(input int ee);
    return (ee > 0) ? WIDTH + 1 : WIDTH + 1;
  endfunction
`endif

  initial begin
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; aluctrl_i = 3'b000;
    data1_i = '0; data2_i = '0;
    next_cyc();
    next_cyc();
    #1;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.result", result_o, '0);
    rst_i = 1'b0;

    // Non-multiply codes never stall.
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      start_i = 1'b1; aluctrl_i = 3'b010; data1_i = 32'd7; data2_i = 32'd6;
      #1;
      chk_ctl("nonmul", 1'b0, 1'b0, 1'b0);
    end
    next_cyc();
    start_i = 1'b0;

    next_cyc();
    run_mul("m7x6",   32'd7,        32'd6,        32'd42,        lat_of(5));
    next_cyc();
    run_mul("m16x16", 32'h0001_0000, 32'h0001_0000, 32'h0,       lat_of(19));
    next_cyc();
    run_mul("mneg",   32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, lat_of(4));
    next_cyc();
    run_mul("mtop",   32'h0000_0003, 32'h8000_0001, 32'h8000_0003, WIDTH + 1);

    // Flush at T+10: multiplier top bit set so both builds are still in RUN.
    next_cyc();
    start_i = 1'b1; aluctrl_i = MUL; data1_i = 32'd123; data2_i = 32'h8000_0001;
    #1;
    chk_ctl("flush.T", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      next_cyc();
    end
    next_cyc();
    flush_i = 1'b1;
    #1;
    chk_ctl("flush.T10", 1'b0, 1'b1, 1'b0);
    next_cyc();
    flush_i = 1'b0;
    #1;
    chk("flush.idle", 32'(busy_o), 32'd0);
    chk("flush.done", 32'(done_o), 32'd0);
    chk("flush.result", result_o, 32'h8000_0003);
    run_mul("m5x5", 32'd5, 32'd5, 32'd25, lat_of(5));

    next_cyc();
    run_mul("mzero", 32'd77, 32'd0, 32'd0, lat_of(2));
    next_cyc();
    run_mul("mone",  32'd9,  32'd1, 32'd9, lat_of(3));

    // Flush in IDLE suppresses accept.
    next_cyc();
    start_i = 1'b1; aluctrl_i = MUL; flush_i = 1'b1; data1_i = 32'd3; data2_i = 32'd3;
    #1;
    chk_ctl("idleflush", 1'b0, 1'b0, 1'b0);
    next_cyc();
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    chk_ctl("idleflush.next", 1'b0, 1'b0, 1'b0);

    // Reset mid-run overrides start and clears result.
    next_cyc();
    start_i = 1'b1; aluctrl_i = MUL; data1_i = 32'd3; data2_i = 32'h8000_0001;
    next_cyc();
    next_cyc();
    rst_i = 1'b1;
    #1;
    chk("rstrun.busy", 32'(busy_o), 32'd1);
    next_cyc();
    rst_i = 1'b0; start_i = 1'b0;
    #1;
    chk_ctl("rstrun", 1'b0, 1'b0, 1'b0);
    chk("rstrun.result", result_o, '0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
